small_poly_encode: RTL and testbench



---
 rtl/small_poly_encode.sv | 205 ++++++++++++++++++++
 tb/tb_small_poly_encode.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/small_poly_encode.sv
// Packs the P ternary coefficients held in the r memory into the Small_encode byte
// stream: four 2-bit codes per byte, LSB first. Optional macro: SMALL_ENC_WEIGHT_CHECK_EN.
module small_poly_encode #(
  parameter int P      = 677,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12,
  parameter int W      = 252
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
  output logic              weight_ok,
`endif
  output logic              enc_err
);

  localparam int NBYTES = (P + 3) / 4;
  localparam int BYTE_W = $clog2(NBYTES);
  localparam int LAST_N = P - 4 * (NBYTES - 1);
  localparam int WC_W   = $clog2(P + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_DONE} state_t;

  // Returns {illegal, mapped}: 00->01, 01->10, 11->00, 10 is illegal and maps to 01.
  function automatic logic [2:0] enc_coef(input logic [1:0] c);
    logic [2:0] r;
    case (c)
      2'b00:   r = 3'b001;
      2'b01:   r = 3'b010;
      2'b11:   r = 3'b000;
      default: r = 3'b101;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [2:0]          ph_q, ph_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic                is_last_s;
  logic [2:0]          n_s;
  logic [1:0]          slot_s;
  logic [2:0]          enc_s;
  logic                nz_s;
  logic                unused_hi_s;

`ifdef SMALL_ENC_WEIGHT_CHECK_EN
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                wok_q, wok_d;
  assign weight_ok = wok_q;
`else
  localparam int unused_w = W + WC_W;
`endif

  assign unused_hi_s = ^mem_rd_data[DATA_W-1:2];
  assign is_last_s   = (byte_q == BYTE_W'(NBYTES - 1));
  assign n_s         = is_last_s ? 3'(LAST_N) : 3'd4;
  assign slot_s      = ph_q[1:0] - 2'd1;
  assign enc_s       = enc_coef(mem_rd_data[1:0]);
  assign nz_s        = (mem_rd_data[1:0] == 2'b01) || (mem_rd_data[1:0] == 2'b11);

  // Next-state and output-register logic; phase ph_q counts issued addresses,
  // each capture lags its address by one cycle, so capture slot = ph_q-1.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    byte_d  = byte_q;
    ph_d    = ph_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
    wcnt_d  = wcnt_q;
    wok_d   = wok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          addr_d  = '0;
          byte_d  = '0;
          ph_d    = 3'd0;
          data_d  = 8'd0;
          err_d   = 1'b0;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
          wcnt_d  = '0;
          wok_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (ph_q != 3'd0) begin
          data_d[{slot_s, 1'b0} +: 2] = enc_s[1:0];
          err_d = err_q | enc_s[2];
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
          if (nz_s) wcnt_d = wcnt_q + WC_W'(1);
          else      wcnt_d = wcnt_q;
`endif
        end else begin
          data_d = data_q;
        end
        if (ph_q == n_s) begin
          state_d = S_OUT;
          valid_d = 1'b1;
          last_d  = is_last_s;
        end else begin
          ph_d = ph_q + 3'd1;
          if ((ph_q + 3'd1) < n_s) addr_d = addr_q + ADDR_W'(1);
          else                     addr_d = addr_q;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          ph_d    = 3'd0;
          if (is_last_s) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
            wok_d   = (wcnt_q == WC_W'(W)) && !err_q;
`endif
          end else begin
            // Full bytes end on address 4k+3, so the next base is simply +1.
            state_d = S_FETCH;
            byte_d  = byte_q + BYTE_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            data_d  = 8'd0;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      byte_q  <= '0;
      ph_q    <= 3'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
      wcnt_q  <= '0;
      wok_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
      wcnt_q  <= wcnt_d;
      wok_q   <= wok_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_addr = addr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign enc_err     = err_q;

endmodule

// File: tb/tb_small_poly_encode.sv
// Directed/table-driven bench for small_poly_encode with a registered-read r memory model.
module tb_small_poly_encode;

  localparam int P = 677;
  localparam int NB = 170;

  typedef struct { int t; int idx; logic [1:0] code; } coef_t;
  typedef struct { int t; int idx; logic [7:0] exp; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic        busy, done, out_valid, out_last, enc_err;
  logic [9:0]  mem_rd_addr;
  logic [11:0] mem_rd_data = 12'd0;
  logic [7:0]  out_data;
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
  logic        weight_ok;
`endif

  logic [11:0] mem [0:P-1];
  logic [7:0]  exp_b [0:NB-1];
  logic [8:0]  cap_q [$];
  coef_t       ctab [21];
  exp_t        etab [7];
  logic        exp_err [4];
  logic        rdy_rand = 1'b0;
  int          n_chk = 0, n_err = 0;

  small_poly_encode dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
    .weight_ok(weight_ok),
`endif
    .enc_err(enc_err));

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= (mem_rd_addr <= 10'd676) ? mem[mem_rd_addr] : 12'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int k);
    int b = 0;
    int e;
    for (int j = 0; j < 4; j++) begin
      if (4 * k + j < P) begin
        case (mem[4 * k + j][1:0])
          2'b01:   e = 2;
          2'b11:   e = 0;
          default: e = 1;
        endcase
        b += e << (2 * j);
      end
    end
    return 8'(b);
  endfunction

  task automatic load_mem(input int t);
    for (int i = 0; i < P; i++) mem[i] = {10'h2A8, 2'b00};
    foreach (ctab[i]) if (ctab[i].t == t) mem[ctab[i].idx][1:0] = ctab[i].code;
    for (int i = 0; i < NB; i++) exp_b[i] = (i == NB - 1) ? 8'h01 : 8'h55;
    foreach (etab[i]) if (etab[i].t == t) exp_b[etab[i].idx] = etab[i].exp;
  endtask

  task automatic exp_from_ref();
    for (int i = 0; i < NB; i++) exp_b[i] = ref_byte(i);
  endtask

  task automatic start_enc(input string nm);
    cap_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, " busy after start"}, 32'(busy), 32'd1);
    chk({nm, " enc_err cleared"}, 32'(enc_err), 32'd0);
  endtask

  task automatic run_stream(input string nm, input int abort_at, input logic xerr);
    int   got = 0, stall_bad = 0, addr_bad = 0;
    logic stalled = 1'b0;
    logic [9:0] prev = 10'd0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (mem_rd_addr > 10'd676) addr_bad++;
      if (stalled && ({out_valid, out_last, out_data} != prev)) stall_bad++;
      if (done) begin got = 1; break; end
      out_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (out_valid && out_ready) cap_q.push_back({out_last, out_data});
      stalled = out_valid && !out_ready;
      prev = {out_valid, out_last, out_data};
      if (abort_at >= 0 && cap_q.size() == abort_at) break;
    end
    chk({nm, " addr range"}, 32'(addr_bad), 32'd0);
    chk({nm, " stall stable"}, 32'(stall_bad), 32'd0);
    if (abort_at < 0) begin
      chk({nm, " done seen"}, 32'(got), 32'd1);
      chk({nm, " busy at done"}, 32'(busy), 32'd0);
      chk({nm, " enc_err at done"}, 32'(enc_err), 32'(xerr));
      @(negedge clk);
      chk({nm, " done one cycle"}, 32'(done), 32'd0);
    end
  endtask

  task automatic compare_bytes(input string nm);
    chk({nm, " byte count"}, 32'(cap_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < cap_q.size(); i++)
      chk($sformatf("%s byte%0d", nm, i), 32'(cap_q[i]), 32'({(i == NB - 1), exp_b[i]}));
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, 32'({busy, done, out_valid, out_last, enc_err, out_data, mem_rd_addr}), 32'd0);
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
    chk({nm, " weight_ok"}, 32'(weight_ok), 32'd0);
`endif
  endtask

  initial begin
    int dn;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < P; i++) mem[i] = 12'd0;
    #1 rst_n = 1'b0;
    #2 chk_outs_zero("reset outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    ctab = '{'{1, 0, 2'b01}, '{1, 1, 2'b11}, '{1, 2, 2'b00}, '{1, 3, 2'b01},
             '{1, 8, 2'b11}, '{1, 9, 2'b11}, '{1, 10, 2'b11}, '{1, 11, 2'b11},
             '{1, 12, 2'b01}, '{1, 13, 2'b01}, '{1, 14, 2'b01}, '{1, 15, 2'b01},
             '{1, 672, 2'b11}, '{1, 674, 2'b01}, '{1, 675, 2'b11},
             '{2, 0, 2'b01}, '{2, 1, 2'b11}, '{2, 3, 2'b01}, '{2, 676, 2'b11},
             '{3, 5, 2'b10}, '{3, 6, 2'b01}};
    etab = '{'{1, 0, 8'h92}, '{1, 2, 8'h00}, '{1, 3, 8'hAA}, '{1, 168, 8'h24},
             '{2, 0, 8'h92}, '{2, 169, 8'h00}, '{3, 1, 8'h65}};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b1};

    for (int t = 0; t < 4; t++) begin
      load_mem(t);
      start_enc($sformatf("T%0d", t));
      run_stream($sformatf("T%0d", t), -1, exp_err[t]);
      compare_bytes($sformatf("T%0d", t));
    end

    for (int i = 0; i < P; i++) begin
      case ($urandom_range(0, 2))
        0:       mem[i] = {10'($urandom), 2'b00};
        1:       mem[i] = {10'($urandom), 2'b01};
        default: mem[i] = {10'($urandom), 2'b11};
      endcase
    end
    exp_from_ref();
    rdy_rand = 1'b1;
    start_enc("RND");
    run_stream("RND", -1, 1'b0);
    compare_bytes("RND");
    rdy_rand = 1'b0;

    load_mem(3);
    start_enc("RST");
    run_stream("RST", 80, 1'b0);
    rst_n = 1'b0;
    #1 chk_outs_zero("RST mid-encode outputs");
    dn = 0;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    chk("RST no done pulse", 32'(dn), 32'd0);
    load_mem(1);
    start_enc("RST re-encode");
    run_stream("RST re-encode", -1, 1'b0);
    compare_bytes("RST re-encode");

`ifdef SMALL_ENC_WEIGHT_CHECK_EN
    for (int i = 0; i < P; i++) mem[i] = (i < 252) ? ((i % 2) ? 12'd3 : 12'd1) : 12'd0;
    exp_from_ref();
    start_enc("W252");
    run_stream("W252", -1, 1'b0);
    compare_bytes("W252");
    chk("W252 weight_ok", 32'(weight_ok), 32'd1);
    mem[251] = 12'd0;
    exp_from_ref();
    start_enc("W251");
    chk("W251 weight_ok cleared", 32'(weight_ok), 32'd0);
    run_stream("W251", -1, 1'b0);
    compare_bytes("W251");
    chk("W251 weight_ok", 32'(weight_ok), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
